i2c_master_byte: RTL and testbench

//  Single-byte I2C master engine driving the split SCL/SDA bench bus upstream of the power-unit memory slave.

---
 rtl/i2c_master_pkg.sv | 30 +++
 rtl/i2c_qtr_tick.sv | 36 +++
 rtl/i2c_master_byte.sv | 146 ++++++++++++++
 tb/tb_i2c_master_byte.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_master_pkg.sv
// rtl/i2c_master_pkg.sv - shared state, quarter and ACK types for the single-byte I2C master
package i2c_master_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WDATA,
      ST_RDATA,
      ST_DATA_ACK,
      ST_STOP,
      ST_DONE
   } state_t;

   typedef logic [1:0] qtr_t;

   localparam logic ACK  = 1'b0;
   localparam logic NACK = 1'b1;

   // Level placed on SDA at the start of q1 for each bit-level state.
   function automatic logic q1_sda(input state_t st, input logic msb);
      case (st)
         ST_ADDR, ST_WDATA: q1_sda = msb;
         ST_STOP:           q1_sda = 1'b0;
         default:           q1_sda = 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// rtl/i2c_qtr_tick.sv - quarter-bit divider; I2C_MASTER_CLK_STRETCH_EN makes STALL freeze the count
module i2c_qtr_tick #(
   parameter int QTR_DIV = 250
) (
   input  logic CLK,
   input  logic RST,
   input  logic EN,
   input  logic STALL,
   output logic TICK
);

   localparam int W = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
   localparam logic [W-1:0] LAST = W'(QTR_DIV - 1);

   logic [W-1:0] cnt;
   logic         hold;

`ifdef I2C_MASTER_CLK_STRETCH_EN
   assign hold = STALL;
`else
   logic unused_stall;
   assign unused_stall = STALL;
   assign hold = 1'b0;
`endif

   assign TICK = EN && !hold && (cnt == LAST);

   always_ff @(posedge CLK) begin
      if (RST || !EN) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_byte.sv
// rtl/i2c_master_byte.sv - one-byte I2C master (START, addr+RW, data, STOP); I2C_MASTER_CLK_STRETCH_EN adds SCL stretching
module i2c_master_byte
   import i2c_master_pkg::*;
#(
   parameter int QTR_DIV = 250
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       SCL_i,
   output logic       SCL_o,
   input  logic       SDA_i,
   output logic       SDA_o,
   input  logic       CMD_VLD,
   output logic       CMD_RDY,
   input  logic       CMD_RW,
   input  logic [6:0] CMD_ADR,
   input  logic [7:0] CMD_DATA,
   output logic       RSP_VLD,
   output logic [7:0] RSP_DATA,
   output logic       RSP_NACK,
   output logic       BUSY
);

   state_t     state;
   qtr_t       qtr;
   logic [2:0] bit_cnt;
   logic [7:0] shreg;
   logic [7:0] wdata;
   logic       rw;
   logic       nack;
   logic       tick;
   logic       run;
   logic       stall;

   assign run   = (state != ST_IDLE) && (state != ST_DONE);
   // Slave holding SCL low while we have released it.
   assign stall = qtr[1] && !SCL_i;

   i2c_qtr_tick #(.QTR_DIV(QTR_DIV)) u_tick (
      .CLK   (CLK),
      .RST   (RST),
      .EN    (run),
      .STALL (stall),
      .TICK  (tick)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state    <= ST_IDLE;
         qtr      <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         wdata    <= '0;
         rw       <= 1'b0;
         nack     <= ACK;
         SCL_o    <= 1'b1;
         SDA_o    <= 1'b1;
         CMD_RDY  <= 1'b0;
         RSP_VLD  <= 1'b0;
         RSP_DATA <= '0;
         RSP_NACK <= 1'b0;
         BUSY     <= 1'b0;
      end else begin
         RSP_VLD <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (CMD_VLD && CMD_RDY) begin
                  state   <= ST_START;
                  shreg   <= {CMD_ADR, CMD_RW};
                  wdata   <= CMD_DATA;
                  rw      <= CMD_RW;
                  nack    <= ACK;
                  qtr     <= '0;
                  bit_cnt <= '0;
                  CMD_RDY <= 1'b0;
                  BUSY    <= 1'b1;
               end else begin
                  CMD_RDY <= 1'b1;
               end
            end
            ST_DONE: begin
               state   <= ST_IDLE;
               CMD_RDY <= 1'b1;
               BUSY    <= 1'b0;
            end
            default: begin
               if (tick) begin
                  qtr <= qtr + 2'd1;
                  case (qtr)
                     2'd0: SDA_o <= q1_sda(state, shreg[7]);
                     2'd1: begin
                        SCL_o <= 1'b1;
                        if (state == ST_START) SDA_o <= 1'b0;
                     end
                     2'd2: begin
                        case (state)
                           ST_ADDR_ACK: nack <= SDA_i;
                           ST_DATA_ACK: if (!rw) nack <= SDA_i;
                           ST_RDATA:    shreg <= {shreg[6:0], SDA_i};
                           ST_STOP:     SDA_o <= 1'b1;
                           default:     ;
                        endcase
                     end
                     default: begin
                        // End of bit: SCL goes low again except after STOP.
                        SCL_o <= (state == ST_STOP);
                        case (state)
                           ST_START: state <= ST_ADDR;
                           ST_ADDR, ST_WDATA: begin
                              shreg   <= {shreg[6:0], 1'b0};
                              bit_cnt <= bit_cnt + 3'd1;
                              if (bit_cnt == 3'd7)
                                 state <= (state == ST_ADDR) ? ST_ADDR_ACK : ST_DATA_ACK;
                           end
                           ST_RDATA: begin
                              bit_cnt <= bit_cnt + 3'd1;
                              if (bit_cnt == 3'd7) state <= ST_DATA_ACK;
                           end
                           ST_ADDR_ACK: begin
                              if (nack == NACK) begin
                                 state <= ST_STOP;
                              end else if (rw) begin
                                 state <= ST_RDATA;
                              end else begin
                                 state <= ST_WDATA;
                                 shreg <= wdata;
                              end
                           end
                           ST_DATA_ACK: state <= ST_STOP;
                           ST_STOP: begin
                              state    <= ST_DONE;
                              RSP_VLD  <= 1'b1;
                              RSP_NACK <= nack;
                              if (rw && nack == ACK) RSP_DATA <= shreg;
                           end
                           default: state <= ST_IDLE;
                        endcase
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_byte.sv
// tb/tb_i2c_master_byte.sv - random-command bench with a memory slave at 7'h2A and a bus protocol monitor
module tb_i2c_master_byte;

   localparam int         Q       = 4;
   localparam logic [6:0] SLV_ADR = 7'h2A;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       SCL_o, SDA_o;
   logic       CMD_VLD, CMD_RDY, CMD_RW;
   logic [6:0] CMD_ADR;
   logic [7:0] CMD_DATA;
   logic       RSP_VLD, RSP_NACK, BUSY;
   logic [7:0] RSP_DATA;

   logic       slv_scl = 1'b1;
   logic       slv_sda = 1'b1;
   logic [7:0] slv_mem = 8'hBC;
   logic       scl_bus, sda_bus;
   logic       stretch_req = 1'b0;

   int         n_cmp = 0;
   int         n_mis = 0;
   int         starts = 0;
   int         stops = 0;
   int         proto_err = 0;
   logic       bus_open = 1'b0;

   logic [7:0] ref_mem = 8'hBC;
   logic [7:0] exp_data = 8'h00;

   assign scl_bus = SCL_o & slv_scl;
   assign sda_bus = SDA_o & slv_sda;

   always #5 CLK = ~CLK;

   i2c_master_byte #(.QTR_DIV(Q)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .SCL_i    (scl_bus),
      .SCL_o    (SCL_o),
      .SDA_i    (sda_bus),
      .SDA_o    (SDA_o),
      .CMD_VLD  (CMD_VLD),
      .CMD_RDY  (CMD_RDY),
      .CMD_RW   (CMD_RW),
      .CMD_ADR  (CMD_ADR),
      .CMD_DATA (CMD_DATA),
      .RSP_VLD  (RSP_VLD),
      .RSP_DATA (RSP_DATA),
      .RSP_NACK (RSP_NACK),
      .BUSY     (BUSY)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Memory slave: bit k counts SCL low phases after START (0-7 addr, 8 ack, 9-16 data, 17 ack).
   initial begin : slave
      logic       ps, pd, s, d, addressed, srw, stretching;
      logic [7:0] sh;
      int         k, held;
      ps = 1'b1; pd = 1'b1; k = 99; sh = 8'h00;
      addressed = 1'b0; srw = 1'b0; stretching = 1'b0; held = 0;
      forever begin
         @(negedge CLK);
         s = scl_bus;
         d = sda_bus;
         if (ps && s && pd && !d) begin
            k = -1; addressed = 1'b0; slv_sda = 1'b1;
         end else if (ps && s && !pd && d) begin
            k = 99; addressed = 1'b0; slv_sda = 1'b1;
         end else if (!ps && s) begin
            if ((k >= 0 && k <= 7) || (k >= 9 && k <= 16)) sh = {sh[6:0], d};
            if (k == 7) begin
               addressed = (sh[7:1] == SLV_ADR);
               srw = sh[0];
            end
            if (k == 16 && addressed && !srw) slv_mem = sh;
         end else if (ps && !s) begin
            if (k < 99) k++;
            slv_sda = 1'b1;
            if (addressed) begin
               if (k == 8) slv_sda = 1'b0;
               else if (k >= 9 && k <= 16 && srw) slv_sda = slv_mem[16-k];
               else if (k == 17 && !srw) slv_sda = 1'b0;
            end
            if (k == 16 && addressed && srw && stretch_req) begin
               slv_scl = 1'b0; stretching = 1'b1; held = 0;
            end
         end
         if (stretching && SCL_o) begin
            if (held == 10) begin
               slv_scl = 1'b1; stretching = 1'b0; stretch_req = 1'b0;
            end else begin
               held++;
            end
         end
         ps = s;
         pd = d;
      end
   end

   // Bus monitor: SDA may only move while SCL is low, apart from one START and one STOP per transfer.
   initial begin : proto
      logic ps, pd, s, d;
      ps = 1'b1; pd = 1'b1;
      forever begin
         @(posedge CLK);
         #2;
         s = scl_bus;
         d = sda_bus;
         if (RST) begin
            bus_open = 1'b0;
         end else if (s != ps && d != pd) begin
            proto_err++;
         end else if (s && ps && d != pd) begin
            if (!d) begin
               if (bus_open) proto_err++;
               bus_open = 1'b1;
               starts++;
            end else begin
               if (!bus_open) proto_err++;
               bus_open = 1'b0;
               stops++;
            end
         end
         ps = s;
         pd = d;
      end
   end

   // Called at a negedge. extra = stretch cycles expected; keep leaves CMD_VLD high for a back-to-back command.
   task automatic run_cmd(input logic rw, input logic [6:0] adr, input logic [7:0] dat,
                          input int extra, input bit keep, output int wait_n);
      logic       nack_exp;
      logic [7:0] data_exp;
      int         lat_exp, n, s0, p0;
      bit         bad;
      nack_exp = (adr != SLV_ADR);
      lat_exp  = (nack_exp ? 44 : 80) * Q + 1 + extra;
      if (rw && !nack_exp) exp_data = ref_mem;
      data_exp = exp_data;
      CMD_RW = rw; CMD_ADR = adr; CMD_DATA = dat; CMD_VLD = 1'b1;
      wait_n = 0;
      while (CMD_RDY !== 1'b1 && wait_n < 2000) begin
         @(negedge CLK);
         wait_n++;
      end
      check("cmd_rdy_wait", CMD_RDY, 1);
      if (CMD_RDY !== 1'b1) begin
         CMD_VLD = 1'b0;
         return;
      end
      s0 = starts;
      p0 = stops;
      @(posedge CLK);
      @(negedge CLK);
      if (!keep) CMD_VLD = 1'b0;
      CMD_RW = 1'($urandom); CMD_ADR = 7'($urandom); CMD_DATA = 8'($urandom);
      n = 1;
      bad = 1'b0;
      while (RSP_VLD !== 1'b1 && n < 3000) begin
         if (CMD_RDY !== 1'b0 || BUSY !== 1'b1) bad = 1'b1;
         @(negedge CLK);
         n++;
      end
      if (CMD_RDY !== 1'b0 || BUSY !== 1'b1) bad = 1'b1;
      check("rsp_vld", RSP_VLD, 1);
      check("latency", n, lat_exp);
      check("rsp_nack", RSP_NACK, nack_exp);
      check("rsp_data", RSP_DATA, data_exp);
      check("rdy_busy_hs", bad, 0);
      check("start_cnt", starts - s0, 1);
      check("stop_cnt", stops - p0, 1);
      if (!rw && !nack_exp) ref_mem = dat;
      if (!keep) begin
         @(negedge CLK);
         check("rsp_pulse", RSP_VLD, 0);
         check("busy_end", BUSY, 0);
         check("rdy_back", CMD_RDY, 1);
      end
   endtask

   initial begin : main
      int   w, n_vld;
      logic rw;
      logic [6:0] adr;
      logic [7:0] dat;
      CMD_VLD = 1'b0; CMD_RW = 1'b0; CMD_ADR = '0; CMD_DATA = '0;
      RST = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_scl", SCL_o, 1);
      check("rst_sda", SDA_o, 1);
      check("rst_rdy", CMD_RDY, 0);
      check("rst_vld", RSP_VLD, 0);
      check("rst_data", RSP_DATA, 0);
      check("rst_nack", RSP_NACK, 0);
      check("rst_busy", BUSY, 0);
      RST = 1'b0;
      @(negedge CLK);
      check("rdy_after_rst", CMD_RDY, 1);

      run_cmd(1'b1, SLV_ADR, 8'h00, 0, 1'b0, w);
      run_cmd(1'b0, SLV_ADR, 8'h5A, 0, 1'b0, w);
      run_cmd(1'b1, SLV_ADR, 8'h00, 0, 1'b0, w);
      run_cmd(1'b1, 7'h2B,   8'h00, 0, 1'b0, w);

      run_cmd(1'b0, SLV_ADR, 8'hC3, 0, 1'b1, w);
      run_cmd(1'b1, SLV_ADR, 8'h00, 0, 1'b0, w);
      check("b2b_accept", w, 1);

      for (int i = 0; i < 12; i++) begin
         rw  = 1'($urandom);
         adr = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV_ADR;
         dat = 8'($urandom);
         run_cmd(rw, adr, dat, 0, 1'b0, w);
      end

      // Reset in the middle of address bit 3 (cycles 65..80 after acceptance).
      CMD_RW = 1'b1; CMD_ADR = SLV_ADR; CMD_VLD = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      CMD_VLD = 1'b0;
      repeat (68) @(negedge CLK);
      RST = 1'b1;
      n_vld = 0;
      @(negedge CLK);
      check("midrst_scl", SCL_o, 1);
      check("midrst_sda", SDA_o, 1);
      check("midrst_busy", BUSY, 0);
      @(negedge CLK);
      check("midrst_rdy", CMD_RDY, 0);
      RST = 1'b0;
      @(negedge CLK);
      check("midrst_rdy_after", CMD_RDY, 1);
      repeat (400) begin
         if (RSP_VLD === 1'b1) n_vld++;
         @(negedge CLK);
      end
      check("midrst_no_vld", n_vld, 0);
      exp_data = 8'h00;
      check("midrst_data", RSP_DATA, 0);
      run_cmd(1'b1, SLV_ADR, 8'h00, 0, 1'b0, w);

`ifdef I2C_MASTER_CLK_STRETCH_EN
      stretch_req = 1'b1;
      run_cmd(1'b1, SLV_ADR, 8'h00, 10, 1'b0, w);
      check("stretch_done", stretch_req, 0);
`endif

      check("protocol", proto_err, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation did not finish, limit 900000 ns");
      $fatal(1);
   end

endmodule
